// File: rtl/sync_tx_sched.sv
// Source-domain scheduler for the pulse-enable synchronizer: round-robin picks one
// of two requesters, latches its word and frames it with an enable pulse plus guard gap.
module sync_tx_sched #(
  parameter int BUS_WIDTH   = 8,
  parameter int EN_HIGH_CYC = 4,
  parameter int EN_LOW_CYC  = 4,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 src_clk,
  input  logic                 src_rst,
  input  logic                 req0_valid,
  input  logic [BUS_WIDTH-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [BUS_WIDTH-1:0] req1_data,
  output logic                 req1_ready,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 grant_id,
  output logic                 busy,
  output logic                 xfer_done
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  localparam logic [CNT_WIDTH-1:0] HI_LOAD = CNT_WIDTH'(EN_HIGH_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] LO_LOAD = CNT_WIDTH'(EN_LOW_CYC - 1);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] bus_q, bus_d;
  logic                 en_q, en_d;
  logic                 gid_q, gid_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  logic                 idle;

  assign idle = (state_q == S_IDLE);

  // A lone requester always wins; under contention the one not granted last wins.
  assign req0_ready = idle && req0_valid && (!req1_valid || last_q);
  assign req1_ready = idle && req1_valid && (!req0_valid || !last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bus_d   = bus_q;
    en_d    = en_q;
    gid_d   = gid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          bus_d   = req1_ready ? req1_data : req0_data;
          gid_d   = req1_ready;
          last_d  = req1_ready;
          en_d    = 1'b1;
          cnt_d   = HI_LOAD;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (cnt_q == '0) begin
          en_d    = 1'b0;
          cnt_d   = LO_LOAD;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bus_q   <= '0;
      en_q    <= 1'b0;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      en_q    <= en_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign unsync_bus = bus_q;
  assign bus_enable = en_q;
  assign grant_id   = gid_q;
  assign busy       = !idle;
  assign xfer_done  = done_q;
endmodule

// File: tb/tb_sync_tx_sched.sv
// Bench for sync_tx_sched: default instance (4/4) and a short-pulse instance (1/1)
// share stimulus; a timeline model (cycles since acceptance) predicts every output.
module tb_sync_tx_sched;
  logic            clk = 1'b0;
  logic            rst;
  logic            v0, v1;
  logic [7:0]      d0, d1;
  logic [1:0]      r0, r1, en, gid, busy, done;
  logic [1:0][7:0] bus;

  always #5 clk = ~clk;

  sync_tx_sched #(.BUS_WIDTH(8), .EN_HIGH_CYC(4), .EN_LOW_CYC(4), .CNT_WIDTH(4)) u_a (
    .src_clk(clk), .src_rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0[0]),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1[0]),
    .unsync_bus(bus[0]), .bus_enable(en[0]), .grant_id(gid[0]),
    .busy(busy[0]), .xfer_done(done[0]));

  sync_tx_sched #(.BUS_WIDTH(8), .EN_HIGH_CYC(1), .EN_LOW_CYC(1), .CNT_WIDTH(1)) u_b (
    .src_clk(clk), .src_rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0[1]),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1[1]),
    .unsync_bus(bus[1]), .bus_enable(en[1]), .grant_id(gid[1]),
    .busy(busy[1]), .xfer_done(done[1]));

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;
  bit chk_on = 0;

  // model: age = cycles since the acceptance edge (0 = nothing since reset)
  int         age [2];
  bit         mlast [2];
  logic [7:0] mbus [2];
  bit         mgid [2];

  int   acA_cyc[$], acA_id[$], acA_done[$], acA_bus[$], acB_cyc[$];
  bit   pendA;

  function automatic int hc(int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int lc(int i); return (i == 0) ? 4 : 1; endfunction
  function automatic bit m_idle(int i); return age[i] == 0 || age[i] > hc(i) + lc(i); endfunction
  function automatic bit m_rdy(int i, int n);
    if (!m_idle(i)) return 1'b0;
    if (n == 0) return v0 && (!v1 || mlast[i] != 1'b0);
    return v1 && (!v0 || mlast[i] != 1'b1);
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h exp=%0h", nm, i, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit a0, a1;
    cyc++;
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk("req0_ready", i, 32'(r0[i]), 32'(m_rdy(i, 0)));
        chk("req1_ready", i, 32'(r1[i]), 32'(m_rdy(i, 1)));
        chk("ready_excl", i, 32'(r0[i] & r1[i]), 32'd0);
        chk("bus_enable", i, 32'(en[i]), 32'(age[i] >= 1 && age[i] <= hc(i)));
        chk("busy", i, 32'(busy[i]), 32'(age[i] >= 1 && age[i] <= hc(i) + lc(i)));
        chk("xfer_done", i, 32'(done[i]), 32'(age[i] == hc(i) + lc(i) + 1));
        chk("grant_id", i, 32'(gid[i]), 32'(mgid[i]));
        chk("unsync_bus", i, 32'(bus[i]), 32'(mbus[i]));
      end
      if (pendA) acA_bus.push_back(int'(bus[0]));
      pendA = r0[0] | r1[0];
      if (r0[0] | r1[0]) begin
        acA_cyc.push_back(cyc); acA_id.push_back(int'(r1[0])); acA_done.push_back(int'(done[0]));
      end
      if (r0[1] | r1[1]) acB_cyc.push_back(cyc);
    end
    // advance model to the state after the coming rising edge
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        age[i] = 0; mlast[i] = 1'b1; mbus[i] = 8'h00; mgid[i] = 1'b0;
      end else begin
        a0 = m_rdy(i, 0); a1 = m_rdy(i, 1);
        if (a0 || a1) begin
          age[i] = 1; mbus[i] = a1 ? d1 : d0; mgid[i] = a1; mlast[i] = a1;
        end else if (age[i] != 0 && age[i] <= hc(i) + lc(i) + 1) begin
          age[i]++;
        end
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic do_reset(); step(); v0 = 0; v1 = 0; rst = 1; step(); rst = 0; endtask
  task automatic clr();
    acA_cyc.delete(); acA_id.delete(); acA_done.delete(); acA_bus.delete(); acB_cyc.delete();
  endtask

  initial begin
    int en_cnt, busy_cnt, done_k, n_done;
    rst = 1; v0 = 0; v1 = 0; d0 = 0; d1 = 0; pendA = 0;
    repeat (2) step();
    rst = 0;
    chk_on = 1;
    @(negedge clk); #1;
    chk("rst_bus", 0, 32'(bus[0]), 32'h00);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);

    // single transfer from req0
    step(); v0 = 1; d0 = 8'hA5;
    @(negedge clk); #1;
    chk("lit_r0_accept", 0, 32'(r0[0]), 32'd1);
    step(); v0 = 0; d0 = 8'h00;
    en_cnt = 0; busy_cnt = 0; done_k = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        chk("lit_bus_a5", 0, 32'(bus[0]), 32'hA5);
        chk("lit_gid0", 0, 32'(gid[0]), 32'd0);
      end
      if (en[0]) begin
        en_cnt++;
        chk("lit_en_window", 0, 32'(k <= 4), 32'd1);
      end
      if (busy[0]) busy_cnt++;
      if (done[0] && done_k == 0) done_k = k;
    end
    chk("lit_en_cycles", 0, 32'(en_cnt), 32'd4);
    chk("lit_busy_cycles", 0, 32'(busy_cnt), 32'd8);
    chk("lit_done_at", 0, 32'(done_k), 32'd9);

    // continuous contention
    do_reset(); clr();
    v0 = 1; v1 = 1; d0 = 8'h11; d1 = 8'h22;
    repeat (31) step();
    v0 = 0; v1 = 0;
    repeat (12) step();
    chk("lit_contend_n", 0, 32'(acA_id.size() >= 4 && acA_bus.size() >= 4), 32'd1);
    if (acA_id.size() >= 4 && acA_bus.size() >= 4)
      for (int j = 0; j < 4; j++) begin
        chk("lit_contend_id", j, 32'(acA_id[j]), 32'(j % 2));
        chk("lit_contend_bus", j, 32'(acA_bus[j]), (j % 2) ? 32'h22 : 32'h11);
        if (j > 0) chk("lit_contend_gap", j, 32'(acA_cyc[j] - acA_cyc[j-1]), 32'd9);
      end
    chk("lit_b_n", 1, 32'(acB_cyc.size() >= 5), 32'd1);
    if (acB_cyc.size() >= 5)
      for (int j = 1; j < 5; j++) chk("lit_b_gap", j, 32'(acB_cyc[j] - acB_cyc[j-1]), 32'd3);

    // lone req1 back-to-back
    do_reset(); clr();
    v1 = 1; d1 = 8'h3C;
    repeat (12) step();
    v1 = 0;
    repeat (12) step();
    chk("lit_r1_n", 0, 32'(acA_id.size() >= 2), 32'd1);
    if (acA_id.size() >= 2) begin
      chk("lit_r1_id0", 0, 32'(acA_id[0]), 32'd1);
      chk("lit_r1_id1", 0, 32'(acA_id[1]), 32'd1);
      chk("lit_r1_gap", 0, 32'(acA_cyc[1] - acA_cyc[0]), 32'd9);
      chk("lit_r1_on_done", 0, 32'(acA_done[1]), 32'd1);
    end

    // reset during the 2nd enable-high cycle
    do_reset(); clr();
    v0 = 1; d0 = 8'h5A;
    step(); v0 = 0;
    step(); rst = 1;
    step(); rst = 0;
    @(negedge clk); #1;
    chk("lit_abort_en", 0, 32'(en[0]), 32'd0);
    chk("lit_abort_bus", 0, 32'(bus[0]), 32'h00);
    chk("lit_abort_busy", 0, 32'(busy[0]), 32'd0);
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      if (done[0]) n_done++;
    end
    chk("lit_abort_nodone", 0, 32'(n_done), 32'd0);
    step(); v0 = 1; v1 = 1; d0 = 8'h01; d1 = 8'h02;
    @(negedge clk); #1;
    chk("lit_abort_r0", 0, 32'(r0[0]), 32'd1);
    chk("lit_abort_r1", 0, 32'(r1[0]), 32'd0);
    step(); v0 = 0; v1 = 0;

    // data changing mid-transfer plus random traffic and occasional reset
    for (int k = 0; k < 3000; k++) begin
      step();
      v0  = ($urandom_range(0, 3) != 0);
      v1  = ($urandom_range(0, 3) != 0);
      d0  = 8'($urandom);
      d1  = 8'($urandom);
      rst = ($urandom_range(0, 199) == 0);
    end
    step(); rst = 0; v0 = 0; v1 = 0;
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
